// File: rtl/uart_frame_rx_pkg.sv
// Shared constants and FSM encodings for the range-finder UART frame receiver.
package uart_frame_rx_pkg;

  localparam int FRAME_BYTES = 13;
  localparam int FRAME_W     = FRAME_BYTES * 8;

  localparam logic [7:0] DEF_FRAME_HDR  = 8'h44;
  localparam logic [7:0] DEF_FRAME_TAIL = 8'h0A;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_e;

  typedef enum logic [1:0] {
    FR_HUNT,
    FR_COLLECT,
    FR_CHECK,
    FR_HOLD
  } frame_state_e;

endpackage

// File: rtl/uart_frame_rx_byte_rx.sv
// 8N1 byte receiver: 2-flop Rx synchroniser, mid-bit sampling, byte and stop-error strobes.
// Latency: strobe one Clk after the stop-bit sample. No backpressure: strobes are fire-and-forget.
module uart_byte_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       Clk,
  input  logic       RstN,
  input  logic       rx_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_dat_o,
  output logic       stop_err_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

  bit_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= BIT_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      BIT_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = BIT_START;
      end
      BIT_START: begin
        // A start bit that is high again at mid-bit was noise, not a byte.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? BIT_IDLE : BIT_DATA;
        end
      end
      BIT_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = BIT_STOP;
        end
      end
      BIT_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = BIT_IDLE;
          vld_d   = rx_sync_q;
          err_d   = !rx_sync_q;
        end
      end
      default: state_d = BIT_IDLE;
    endcase
  end

  assign byte_vld_o = vld_q;
  assign byte_dat_o = shift_q;
  assign stop_err_o = err_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Assembles 13-byte header/tail-delimited frames into DataOut with an EN_HOLD-cycle DataEn level.
// Latency: DataEn rises 2 Clk after the last byte strobe; no backpressure, bytes during HOLD are dropped.
// Optional RX_FRAME_TIMEOUT_EN: abort a frame left idle for 20*CLK_DIV cycles in COLLECT.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int         CLK_DIV    = 434,
  parameter logic [7:0] FRAME_HDR  = DEF_FRAME_HDR,
  parameter logic [7:0] FRAME_TAIL = DEF_FRAME_TAIL,
  parameter int         EN_HOLD    = 4
) (
  input  logic               Clk,
  input  logic               RstN,
  input  logic               Rx,
  output logic               DataEn,
  output logic [FRAME_W-1:0] DataOut,
  output logic               FrameErr
);

  logic rst_meta_q, rst_n_q;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  logic       byte_vld, stop_err;
  logic [7:0] byte_dat;

  uart_byte_rx #(
    .CLK_DIV(CLK_DIV)
  ) u_byte_rx (
    .Clk       (Clk),
    .RstN      (rst_n_q),
    .rx_i      (Rx),
    .byte_vld_o(byte_vld),
    .byte_dat_o(byte_dat),
    .stop_err_o(stop_err)
  );

  frame_state_e       state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         hold_q, hold_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [FRAME_W-1:0] dout_q, dout_d;
  logic               den_q, den_d;
  logic               ferr_q, ferr_d;
  logic               timeout;
  logic [FRAME_W-1:0] shadow_push;

  // Shifting in keeps byte 0 at the top once all 13 slots are filled.
  assign shadow_push = {shadow_q[FRAME_W-9:0], byte_dat};

`ifdef RX_FRAME_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(20 * CLK_DIV - 1);
  logic [15:0] idle_q, idle_d;

  always_comb begin
    idle_d = '0;
    if (state_d == FR_COLLECT) idle_d = byte_vld ? 16'd1 : idle_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge rst_n_q) begin
    if (!rst_n_q) idle_q <= '0;
    else          idle_q <= idle_d;
  end

  assign timeout = (idle_q == TO_LIMIT);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge Clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q  <= FR_HUNT;
      cnt_q    <= '0;
      hold_q   <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      den_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      den_q    <= den_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    den_d    = den_q;
    ferr_d   = 1'b0;
    case (state_q)
      FR_HUNT: begin
        if (byte_vld && byte_dat == FRAME_HDR) begin
          shadow_d = shadow_push;
          cnt_d    = 4'd1;
          state_d  = FR_COLLECT;
        end
      end
      FR_COLLECT: begin
        if (stop_err || timeout) begin
          ferr_d  = 1'b1;
          cnt_d   = '0;
          state_d = FR_HUNT;
        end else if (byte_vld) begin
          shadow_d = shadow_push;
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'(FRAME_BYTES - 1)) state_d = FR_CHECK;
        end
      end
      FR_CHECK: begin
        cnt_d = '0;
        if (shadow_q[7:0] == FRAME_TAIL) begin
          dout_d  = shadow_q;
          den_d   = 1'b1;
          hold_d  = 8'd1;
          state_d = FR_HOLD;
        end else begin
          ferr_d  = 1'b1;
          state_d = FR_HUNT;
        end
      end
      FR_HOLD: begin
        if (hold_q == 8'(EN_HOLD)) begin
          den_d   = 1'b0;
          state_d = FR_HUNT;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = FR_HUNT;
    endcase
  end

  assign DataEn   = den_q;
  assign DataOut  = dout_q;
  assign FrameErr = ferr_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Random and directed frame stimulus against a byte-stream reference model of the frame receiver.
`timescale 1ns/1ps
module tb_uart_frame_rx;

  localparam int CLK_DIV = 16;
  localparam int EN_HOLD = 4;
  // 2 sync flops + edge register, half a start bit, 8 data bits + stop bit to its mid-bit sample.
  localparam int LAT     = 3 + CLK_DIV / 2 + 9 * CLK_DIV;
  localparam int TO_CYC  = 20 * CLK_DIV;
  localparam int MAXC    = 65536;
  localparam logic [103:0] CLEAN_W = 104'h44_3031_3233_2E34_3536_376D_0D0A;

  logic         Clk = 1'b0;
  logic         RstN;
  logic         Rx;
  logic         DataEn;
  logic         FrameErr;
  logic [103:0] DataOut;

  uart_frame_rx #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_HDR (8'h44),
    .FRAME_TAIL(8'h0A),
    .EN_HOLD   (EN_HOLD)
  ) dut (
    .Clk     (Clk),
    .RstN    (RstN),
    .Rx      (Rx),
    .DataEn  (DataEn),
    .DataOut (DataOut),
    .FrameErr(FrameErr)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Reference model: expected outputs per cycle, derived from the byte stream.
  bit           exp_en  [MAXC];
  bit           exp_err [MAXC];
  logic [103:0] dout_chg [int];
  logic [103:0] exp_dout = '0;
  bit           collecting = 1'b0;
  logic [7:0]   frm [$];
  int           last_s = 0;
  int           last_p0 = 0;

  task automatic mark_err(input int c);
    if (c < MAXC) exp_err[c] = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok, input int s);
    logic [103:0] v;
    if (!stop_ok) begin
      if (collecting) mark_err(s + 1);
      collecting = 1'b0;
      return;
    end
    if (!collecting) begin
      if (b == 8'h44) begin
        collecting = 1'b1;
        frm = {b};
        last_s = s;
      end
      return;
    end
    frm.push_back(b);
    last_s = s;
    if (frm.size() == 13) begin
      collecting = 1'b0;
      if (b == 8'h0A) begin
        v = '0;
        foreach (frm[i]) v = {v[95:0], frm[i]};
        dout_chg[s + 2] = v;
        for (int k = 0; k < EN_HOLD; k++) if (s + 2 + k < MAXC) exp_en[s + 2 + k] = 1'b1;
      end else begin
        mark_err(s + 2);
      end
    end
  endtask

  // Called when the line is about to go quiet for good.
  task automatic model_line_idle();
`ifdef RX_FRAME_TIMEOUT_EN
    if (collecting) mark_err(last_s + TO_CYC);
`endif
    collecting = 1'b0;
  endtask

  task automatic check(input string name, input logic [103:0] got, input logic [103:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (dout_chg.exists(cyc)) exp_dout = dout_chg[cyc];
    if (chk_on && cyc < MAXC) begin
      checks += 3;
      if (DataEn !== exp_en[cyc]) begin
        errors++;
        $display("FAIL data_en cyc=%0d got=%b exp=%b", cyc, DataEn, exp_en[cyc]);
      end
      if (FrameErr !== exp_err[cyc]) begin
        errors++;
        $display("FAIL frame_err cyc=%0d got=%b exp=%b", cyc, FrameErr, exp_err[cyc]);
      end
      if (DataOut !== exp_dout) begin
        errors++;
        $display("FAIL data_out cyc=%0d got=%h exp=%h", cyc, DataOut, exp_dout);
      end
    end
  end

  int   en_cycles = 0;
  int   err_pulses = 0;
  int   rise_cyc = 0;
  logic den_prev = 1'b0;
  always @(negedge Clk) begin
    if (DataEn === 1'b1) en_cycles++;
    if (FrameErr === 1'b1) err_pulses++;
    if (DataEn === 1'b1 && den_prev !== 1'b1) rise_cyc = cyc;
    den_prev = DataEn;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] sym;
    @(posedge Clk);
    #1;
    last_p0 = cyc;
    model_byte(b, stop_ok, cyc + LAT);
    sym = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      Rx = sym[i];
      repeat (CLK_DIV) @(posedge Clk);
      #1;
    end
    Rx = 1'b1;
    if (!stop_ok) idle(CLK_DIV);
  endtask

  task automatic send_frame(input logic [7:0] f [13], input int bad_pos);
    for (int i = 0; i < 13; i++) send_byte(f[i], i != bad_pos);
  endtask

  logic [7:0] clean_f [13];
  logic [7:0] f [13];
  int en0, err0, nz, kind, bad;

  initial begin
    clean_f = '{8'h44, 8'h30, 8'h31, 8'h32, 8'h33, 8'h2E, 8'h34,
                8'h35, 8'h36, 8'h37, 8'h6D, 8'h0D, 8'h0A};
    RstN = 1'b0;
    Rx   = 1'b1;
    idle(3);
    check("rst_data_en", 104'(DataEn), 104'd0);
    check("rst_data_out", DataOut, 104'd0);
    check("rst_frame_err", 104'(FrameErr), 104'd0);
    RstN = 1'b1;
    idle(4);
    chk_on = 1'b1;

    // Clean frame, pinned against hand-computed values.
    en0 = en_cycles; err0 = err_pulses;
    send_frame(clean_f, -1);
    idle(20);
    check("clean_data_out", DataOut, CLEAN_W);
    check("clean_en_len", 104'(en_cycles - en0), 104'd4);
    check("clean_en_rise", 104'(rise_cyc - last_p0), 104'd157);
    check("clean_no_err", 104'(err_pulses - err0), 104'd0);

    // Leading noise bytes are ignored silently.
    en0 = en_cycles; err0 = err_pulses;
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_frame(clean_f, -1);
    idle(20);
    check("noise_data_out", DataOut, CLEAN_W);
    check("noise_en_len", 104'(en_cycles - en0), 104'd4);
    check("noise_no_err", 104'(err_pulses - err0), 104'd0);

    // Bad tail: one error, no DataEn, DataOut kept.
    en0 = en_cycles; err0 = err_pulses;
    f = clean_f;
    f[12] = 8'h0B;
    send_frame(f, -1);
    idle(20);
    check("badtail_err", 104'(err_pulses - err0), 104'd1);
    check("badtail_no_en", 104'(en_cycles - en0), 104'd0);
    check("badtail_data_out", DataOut, CLEAN_W);

    // Stop-bit error on byte 5, then a clean frame recovers.
    en0 = en_cycles; err0 = err_pulses;
    send_frame(clean_f, 5);
    idle(20);
    check("stoperr_err", 104'(err_pulses - err0), 104'd1);
    check("stoperr_no_en", 104'(en_cycles - en0), 104'd0);
    send_frame(clean_f, -1);
    idle(20);
    check("stoperr_recover_en", 104'(en_cycles - en0), 104'd4);

    // Three-cycle glitch: no byte, no error, still hunting.
    en0 = en_cycles; err0 = err_pulses;
    @(posedge Clk); #1;
    Rx = 1'b0;
    idle(3);
    Rx = 1'b1;
    idle(60);
    check("glitch_no_err", 104'(err_pulses - err0), 104'd0);
    check("glitch_no_en", 104'(en_cycles - en0), 104'd0);
    send_frame(clean_f, -1);
    idle(20);
    check("glitch_then_frame_en", 104'(en_cycles - en0), 104'd4);

    // Random frames with noise, corrupted tails and stop errors.
    for (int it = 0; it < 8; it++) begin
      nz = $urandom_range(0, 2);
      for (int j = 0; j < nz; j++) send_byte(8'($urandom_range(0, 255)), 1'b1);
      f[0] = 8'h44;
      for (int j = 1; j < 12; j++) f[j] = 8'($urandom_range(0, 255));
      f[12] = 8'h0A;
      kind = $urandom_range(0, 3);
      if (kind == 2) f[12] = 8'h0A ^ 8'($urandom_range(1, 255));
      bad = (kind == 3) ? $urandom_range(1, 11) : -1;
      send_frame(f, bad);
      idle($urandom_range(0, 20));
    end
    idle(20);

    // Reset mid-frame discards the partial frame and clears DataOut.
    for (int i = 0; i < 5; i++) send_byte(clean_f[i], 1'b1);
    idle(5);
    chk_on = 1'b0;
    RstN = 1'b0;
    collecting = 1'b0;
    dout_chg[cyc] = '0;
    #1;
    check("midrst_data_out", DataOut, 104'd0);
    check("midrst_data_en", 104'(DataEn), 104'd0);
    idle(3);
    RstN = 1'b1;
    idle(4);
    chk_on = 1'b1;
    send_frame(clean_f, -1);
    idle(20);
    check("postrst_data_out", DataOut, CLEAN_W);

    // Truncated frame followed by a long quiet line.
    err0 = err_pulses;
    for (int i = 0; i < 6; i++) send_byte(clean_f[i], 1'b1);
    model_line_idle();
    idle(TO_CYC + 80);
`ifdef RX_FRAME_TIMEOUT_EN
    check("timeout_err", 104'(err_pulses - err0), 104'd1);
`else
    check("timeout_none", 104'(err_pulses - err0), 104'd0);
`endif

    idle(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog cyc=%0d required finish before %0d", cyc, MAXC);
    $fatal(1, "watchdog expired");
  end

endmodule
